// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, with a final sign-correction cycle.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned DW    = 2 * XLEN;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [2:0]       fn;
  logic [XLEN-1:0]  a_mag, b_mag, quo;
  logic [DW-1:0]    acc;
  logic [XLEN:0]    rem;
  logic             neg;
  logic [CNT_W-1:0] cnt, cnt_inc;

  logic             accept_c, a_neg_c, b_neg_c, in_neg_c;
  logic             div_zero_c, div_ovf_c, special_c;
  logic [XLEN-1:0]  in_a_mag_c, in_b_mag_c;
  logic [XLEN:0]    mul_sum_c;
  logic [XLEN+1:0]  shifted_c, diff_c;
  logic [DW-1:0]    prod_fix_c;
  logic [XLEN-1:0]  div_sel_c, fix_res_c;

  // Operand decode: signedness per funct3, magnitudes, result sign, special divides
  always_comb begin
    a_neg_c    = 1'b0;
    b_neg_c    = 1'b0;
    in_neg_c   = 1'b0;
    case (funct3)
      3'b001, 3'b100: begin
        a_neg_c  = op_a[XLEN-1];
        b_neg_c  = op_b[XLEN-1];
        in_neg_c = op_a[XLEN-1] ^ op_b[XLEN-1];
      end
      3'b110: begin
        a_neg_c  = op_a[XLEN-1];
        b_neg_c  = op_b[XLEN-1];
        in_neg_c = op_a[XLEN-1];
      end
      3'b010: begin
        a_neg_c  = op_a[XLEN-1];
        in_neg_c = op_a[XLEN-1];
      end
      default: ;
    endcase
    in_a_mag_c = a_neg_c ? -op_a : op_a;
    in_b_mag_c = b_neg_c ? -op_b : op_b;
    div_zero_c = funct3[2] && (op_b == '0);
    div_ovf_c  = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                 (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special_c  = div_zero_c || div_ovf_c;
    accept_c   = start && !flush && ((state == IDLE) || (state == DONE));
  end

  // Iteration datapath and final sign-corrected result select
  always_comb begin
    cnt_inc    = cnt + CNT_W'(1);
    mul_sum_c  = {1'b0, acc[DW-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : {(XLEN+1){1'b0}});
    shifted_c  = {rem, quo[XLEN-1]};
    diff_c     = shifted_c - {2'b00, b_mag};
    prod_fix_c = neg ? -acc : acc;
    div_sel_c  = fn[1] ? rem[XLEN-1:0] : quo;
    if (!fn[2]) begin
      fix_res_c = (fn[1:0] == 2'b00) ? prod_fix_c[XLEN-1:0] : prod_fix_c[DW-1:XLEN];
    end else begin
      fix_res_c = neg ? -div_sel_c : div_sel_c;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; special divides bypass iteration and finalise in FIX
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (accept_c) begin
          if (!funct3[2])     state_nxt = MUL;
          else if (special_c) state_nxt = FIX;
          else                state_nxt = DIV;
        end
      end
      MUL, DIV: begin
        if (flush)                    state_nxt = IDLE;
        else if (cnt_inc == CNT_LAST) state_nxt = FIX;
      end
      FIX:     state_nxt = flush ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, per-cycle iteration and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      fn     <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc    <= '0;
      quo    <= '0;
      rem    <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      busy <= (state_nxt == MUL) || (state_nxt == DIV) || (state_nxt == FIX);
      done <= (state_nxt == DONE);
      if (accept_c) begin
        fn    <= funct3;
        a_mag <= in_a_mag_c;
        b_mag <= in_b_mag_c;
        cnt   <= '0;
        acc   <= {{XLEN{1'b0}}, in_b_mag_c};
        if (div_zero_c) begin
          quo <= '1;
          rem <= {1'b0, op_a};
          neg <= 1'b0;
        end else if (div_ovf_c) begin
          quo <= op_a;
          rem <= '0;
          neg <= 1'b0;
        end else begin
          quo <= in_a_mag_c;
          rem <= '0;
          neg <= in_neg_c;
        end
      end else begin
        case (state)
          MUL: begin
            acc <= {mul_sum_c, acc[XLEN-1:1]};
            cnt <= cnt_inc;
          end
          DIV: begin
            quo <= {quo[XLEN-2:0], ~diff_c[XLEN+1]};
            rem <= diff_c[XLEN+1] ? shifted_c[XLEN:0] : diff_c[XLEN:0];
            cnt <= cnt_inc;
          end
          FIX: if (!flush) result <= fix_res_c;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (XLEN=32).
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            reset;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add_vec(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name);
    vec_t v;
    v.fn = fn; v.a = a; v.b = b; v.exp = exp; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Drive a start for one edge (E0); returns just after E0
  task automatic launch(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    funct3 = fn;
    op_a   = a;
    op_b   = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // k = index of edge after E0 whose following cycle shows done (-1 on timeout)
  task automatic wait_done(input int k0, output int k, output logic busy_first);
    bit got;
    got        = 1'b0;
    k          = k0;
    busy_first = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      k++;
      if (k == 0) busy_first = busy;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) k = -1;
  endtask

  initial begin
    int          k;
    logic        bf;
    int          cnt_done;
    int          cnt_busy;
    logic [31:0] last_res;

    reset = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'b000; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.busy",   32'(busy),   32'd0);
    check("reset.done",   32'(done),   32'd0);
    check("reset.result", result,      32'd0);
    reset = 1'b0;

    add_vec(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7x-3");
    add_vec(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min2");
    add_vec(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max2");
    add_vec(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu_m1xmax");
    add_vec(3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 33, "mulh_7x-3");
    add_vec(3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, "mulhsu_m1x2");
    add_vec(3'b010, 32'd2,        32'hFFFFFFFF, 32'h00000001, 33, "mulhsu_2xmax");
    add_vec(3'b000, 32'h00010000, 32'h00010000, 32'h00000000, 33, "mul_2p32");
    add_vec(3'b011, 32'h00010000, 32'h00010000, 32'h00000001, 33, "mulhu_2p32");
    add_vec(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_-7/2");
    add_vec(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_-7/2");
    add_vec(3'b101, 32'd100,      32'd7,        32'd14,       33, "divu_100/7");
    add_vec(3'b111, 32'd100,      32'd7,        32'd2,        33, "remu_100/7");
    add_vec(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, "div_7/-2");
    add_vec(3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33, "rem_7/-2");
    add_vec(3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33, "divu_max/1");
    add_vec(3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "div_5/0");
    add_vec(3'b111, 32'd5,        32'd0,        32'd5,        1,  "remu_5/0");
    add_vec(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf");
    add_vec(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem_ovf");
    add_vec(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_5/0");
    add_vec(3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1,  "rem_-5/0");

    // Every op after the first is started in the previous op's done cycle
    @(negedge clk);
    launch(vecs[0].fn, vecs[0].a, vecs[0].b);
    for (int i = 0; i < vecs.size(); i++) begin
      wait_done(-1, k, bf);
      check($sformatf("%s.latency", vecs[i].name), 32'(k), 32'(vecs[i].lat));
      check($sformatf("%s.result", vecs[i].name), result, vecs[i].exp);
      check($sformatf("%s.busy_at_done", vecs[i].name), 32'(busy), 32'd0);
      if (vecs[i].lat == 33) check($sformatf("%s.busy_after_e0", vecs[i].name), 32'(bf), 32'd1);
      if (i + 1 < vecs.size()) launch(vecs[i+1].fn, vecs[i+1].a, vecs[i+1].b);
    end
    last_res = vecs[vecs.size()-1].exp;

    // Flush a DIVU at edge 10 of its run
    repeat (3) @(negedge clk);
    launch(3'b101, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush.busy_next", 32'(busy), 32'd0);
    check("flush.result_kept", result, last_res);
    cnt_done = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) cnt_done++;
    end
    check("flush.no_done", 32'(cnt_done), 32'd0);
    check("flush.result_after", result, last_res);

    // start together with flush launches nothing
    start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    cnt_done = 0;
    cnt_busy = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    check("start_flush.no_done", 32'(cnt_done), 32'd0);
    check("start_flush.no_busy", 32'(cnt_busy), 32'd0);
    check("start_flush.result", result, last_res);

    // start while busy is ignored
    launch(3'b011, 32'h00010000, 32'h00010000);
    repeat (5) @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd3;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(6, k, bf);
    check("busy_start.latency", 32'(k), 32'd33);
    check("busy_start.result", result, 32'h00000001);

    // Reset at edge 15 of a MUL, then a normal op
    @(negedge clk);
    launch(3'b000, 32'd7, 32'hFFFFFFFD);
    repeat (15) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset.busy",   32'(busy), 32'd0);
    check("midreset.done",   32'(done), 32'd0);
    check("midreset.result", result,    32'd0);
    launch(3'b101, 32'd100, 32'd7);
    wait_done(-1, k, bf);
    check("post_reset.latency", 32'(k), 32'd33);
    check("post_reset.result",  result, 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
